// File: rtl/timer_run_ctrl.sv
// Run/pause/direction sequencer for the two-digit stopwatch/countdown datapath.
// Define TIMER_AUTO_RELOAD_EN to re-arm the countdown after the expiry blink sequence.
module timer_run_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned BLINK_COUNT = 3,
  parameter int unsigned DEB_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_load_i,
  input  logic       key_pause_i,
  input  logic       key_speed_i,
  input  logic       key_prec_i,
  input  logic       tick_1hz_i,
  input  logic       tick_2hz_i,
  input  logic       tick_4hz_i,
  input  logic       tick_10hz_i,
  input  logic       cnt_zero_i,
  input  logic       cnt_low_i,
  output logic       cnt_step_o,
  output logic       cnt_dir_o,
  output logic       cnt_clear_o,
  output logic       cnt_load_o,
  output logic       prec_en_o,
  output logic [1:0] speed_sel_o,
  output logic [2:0] state_o,
  output logic       led_o
);

  localparam int unsigned NumKeys = 6;
  localparam int unsigned BlinkW  = $clog2(BLINK_COUNT + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRunUp   = 3'd1,
    StRunDown = 3'd2,
    StPaused  = 3'd3,
    StExpired = 3'd4
  } state_e;

  logic [NumKeys-1:0] raw_keys, sync1_q, sync2_q, deb_lvl_q, deb_prev_q, key_rise;
  logic [DEB_W-1:0]   deb_cnt_q [NumKeys];

  state_e            state_q;
  logic              cnt_step_q, cnt_dir_q, cnt_clear_q, cnt_load_q, prec_q, led_q;
  logic [1:0]        speed_q;
  logic [BlinkW-1:0] blink_q;
  logic              sel_tick;

  assign raw_keys = {key_prec_i, key_speed_i, key_pause_i, key_load_i, key_down_i, key_up_i};

  // Level flips only after DEB_CYCLES consecutive samples that differ from it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_lvl_q  <= '0;
      deb_prev_q <= '0;
      for (int k = 0; k < NumKeys; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q    <= raw_keys;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_lvl_q;
      for (int k = 0; k < NumKeys; k++) begin
        if (sync2_q[k] == deb_lvl_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt_q[k] <= '0;
          deb_lvl_q[k] <= sync2_q[k];
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign key_rise = deb_lvl_q & ~deb_prev_q;

  always_comb begin
    sel_tick = 1'b0;
    if (prec_q) begin
      sel_tick = tick_10hz_i;
    end else begin
      case (speed_q)
        2'd0:    sel_tick = tick_1hz_i;
        2'd1:    sel_tick = tick_2hz_i;
        default: sel_tick = tick_4hz_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_step_q  <= 1'b0;
      cnt_dir_q   <= 1'b0;
      cnt_clear_q <= 1'b0;
      cnt_load_q  <= 1'b0;
      prec_q      <= 1'b0;
      speed_q     <= 2'd0;
      led_q       <= 1'b0;
      blink_q     <= '0;
    end else begin
      cnt_step_q  <= 1'b0;
      cnt_clear_q <= 1'b0;
      cnt_load_q  <= 1'b0;
      if (key_rise[4]) speed_q <= (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
      if (key_rise[5]) prec_q <= ~prec_q;

      if (key_rise[0]) begin
        cnt_clear_q <= 1'b1;
        cnt_dir_q   <= 1'b0;
        state_q     <= StRunUp;
        led_q       <= 1'b0;
      end else if (key_rise[1]) begin
        cnt_load_q <= 1'b1;
        cnt_dir_q  <= 1'b1;
        state_q    <= StRunDown;
        led_q      <= 1'b0;
      end else if (key_rise[2] && state_q != StExpired) begin
        cnt_load_q <= 1'b1;
        state_q    <= StIdle;
        led_q      <= 1'b0;
      end else if (key_rise[3] && (state_q == StRunUp || state_q == StRunDown)) begin
        state_q <= StPaused;
        led_q   <= 1'b0;
      end else if (key_rise[3] && state_q == StPaused) begin
        state_q <= cnt_dir_q ? StRunDown : StRunUp;
      end else begin
        case (state_q)
          StRunUp: begin
            cnt_step_q <= sel_tick;
            led_q      <= 1'b0;
          end
          StRunDown: begin
            // A tick at zero expires instead of stepping, so the count never wraps.
            if (sel_tick && cnt_zero_i) begin
              state_q <= StExpired;
              blink_q <= '0;
              led_q   <= 1'b0;
            end else begin
              cnt_step_q <= sel_tick;
              if (cnt_low_i && !cnt_zero_i) begin
                if (tick_2hz_i) led_q <= ~led_q;
              end else begin
                led_q <= 1'b0;
              end
            end
          end
          StExpired: begin
            if (tick_2hz_i) begin
              if (led_q) begin
                led_q   <= 1'b0;
                blink_q <= blink_q + 1'b1;
                if (blink_q == BlinkW'(BLINK_COUNT - 1)) begin
`ifdef TIMER_AUTO_RELOAD_EN
                  cnt_load_q <= 1'b1;
                  cnt_dir_q  <= 1'b1;
                  state_q    <= StRunDown;
`else
                  state_q    <= StIdle;
`endif
                end
              end else begin
                led_q <= 1'b1;
              end
            end
          end
          default: led_q <= 1'b0;
        endcase
      end
    end
  end

  assign cnt_step_o  = cnt_step_q;
  assign cnt_dir_o   = cnt_dir_q;
  assign cnt_clear_o = cnt_clear_q;
  assign cnt_load_o  = cnt_load_q;
  assign prec_en_o   = prec_q;
  assign speed_sel_o = speed_q;
  assign state_o     = state_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Randomized bench for timer_run_ctrl against a press-level and tick-level behavioural model.
module tb_timer_run_ctrl;

  localparam int unsigned DebCycles  = 16;
  localparam int unsigned BlinkCount = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] keys = '0;  // {prec, speed, pause, load, down, up}
  logic       t1 = 0, t2 = 0, t4 = 0, t10 = 0, zero = 0, low = 0;
  logic       cnt_step, cnt_dir, cnt_clear, cnt_load, prec_en, led;
  logic [1:0] speed_sel;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the visible controller state.
  int m_state, m_speed, m_blink;
  bit m_dir, m_prec, m_led;

  always #5 clk = ~clk;

  timer_run_ctrl #(.DEB_CYCLES(DebCycles), .BLINK_COUNT(BlinkCount), .DEB_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_up_i   (keys[0]),
    .key_down_i (keys[1]),
    .key_load_i (keys[2]),
    .key_pause_i(keys[3]),
    .key_speed_i(keys[4]),
    .key_prec_i (keys[5]),
    .tick_1hz_i (t1),
    .tick_2hz_i (t2),
    .tick_4hz_i (t4),
    .tick_10hz_i(t10),
    .cnt_zero_i (zero),
    .cnt_low_i  (low),
    .cnt_step_o (cnt_step),
    .cnt_dir_o  (cnt_dir),
    .cnt_clear_o(cnt_clear),
    .cnt_load_o (cnt_load),
    .prec_en_o  (prec_en),
    .speed_sel_o(speed_sel),
    .state_o    (state),
    .led_o      (led)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs(input bit e_step, input bit e_clr, input bit e_ld);
    check_eq("state", int'(state), m_state);
    check_eq("cnt_step", int'(cnt_step), int'(e_step));
    check_eq("cnt_clear", int'(cnt_clear), int'(e_clr));
    check_eq("cnt_load", int'(cnt_load), int'(e_ld));
    check_eq("cnt_dir", int'(cnt_dir), int'(m_dir));
    check_eq("speed_sel", int'(speed_sel), m_speed);
    check_eq("prec_en", int'(prec_en), int'(m_prec));
    check_eq("led", int'(led), int'(m_led));
  endtask

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_blink = 0;
    m_dir = 0; m_prec = 0; m_led = 0;
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    keys = '0;
    {t1, t2, t4, t10, zero, low} = '0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // One clock with the given rate pulses and datapath flags; outputs checked after the edge.
  task automatic drive_cycle(input bit a1, input bit a2, input bit a4, input bit a10,
                             input bit z, input bit l);
    bit sel, e_step, e_ld;
    e_step = 0;
    e_ld   = 0;
    {t1, t2, t4, t10, zero, low} = {a1, a2, a4, a10, z, l};
    sel = m_prec ? a10 : (m_speed == 0 ? a1 : (m_speed == 1 ? a2 : a4));
    case (m_state)
      1: begin e_step = sel; m_led = 0; end
      2: begin
        if (sel && z) begin
          m_state = 4; m_blink = 0; m_led = 0;
        end else begin
          e_step = sel;
          if (l && !z) begin
            if (a2) m_led = !m_led;
          end else begin
            m_led = 0;
          end
        end
      end
      4: begin
        if (a2) begin
          if (m_led) begin
            m_led = 0;
            m_blink++;
            if (m_blink == BlinkCount) begin
`ifdef TIMER_AUTO_RELOAD_EN
              e_ld = 1; m_dir = 1; m_state = 2;
`else
              m_state = 0;
`endif
            end
          end else begin
            m_led = 1;
          end
        end
      end
      default: m_led = 0;
    endcase
    @(posedge clk);
    #1;
    check_outputs(e_step, 1'b0, e_ld);
  endtask

  task automatic random_cycle();
    bit z, l;
    z = (m_state == 2) && ($urandom_range(0, 15) == 0);
    l = z || ($urandom_range(0, 1) == 1);
    drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, z, l);
  endtask

  // Holds keys for `hold` clocks then releases; a hold of DebCycles+4 or more counts as a press.
  task automatic press(input logic [5:0] k, input int hold);
    int n_clr, n_ld, n_step;
    bit e_clr, e_ld;
    n_clr = 0; n_ld = 0; n_step = 0; e_clr = 0; e_ld = 0;
    {t1, t2, t4, t10, zero, low} = '0;
    keys = k;
    for (int i = 0; i < hold + int'(DebCycles) + 6; i++) begin
      if (i == hold) keys = '0;
      @(posedge clk);
      #1;
      n_clr  += int'(cnt_clear);
      n_ld   += int'(cnt_load);
      n_step += int'(cnt_step);
    end
    if (hold >= int'(DebCycles) + 4) begin
      if (k[0]) begin
        e_clr = 1; m_dir = 0; m_state = 1;
      end else if (k[1]) begin
        e_ld = 1; m_dir = 1; m_state = 2;
      end else if (k[2] && m_state != 4) begin
        e_ld = 1; m_state = 0;
      end else if (k[3]) begin
        if (m_state == 1 || m_state == 2) m_state = 3;
        else if (m_state == 3) m_state = m_dir ? 2 : 1;
      end
      if (k[4]) m_speed = (m_speed + 1) % 3;
      if (k[5]) m_prec = !m_prec;
    end
    if (m_state != 4) m_led = 0;
    check_eq("press_clear_pulses", n_clr, int'(e_clr));
    check_eq("press_load_pulses", n_ld, int'(e_ld));
    check_eq("press_step_pulses", n_step, 0);
    check_outputs(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_cycles(3);

    // Count up: three 1 Hz ticks give three steps.
    press(6'b000001, 20);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0);
      drive_cycle(0, 1, 1, 1, 0, 0);
    end

    // Bouncy pause: bounce must not register, then the long hold pauses exactly once.
    {t1, t2, t4, t10, zero, low} = '0;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ((i / 3) % 2 == 0);
      @(posedge clk);
    end
    #1;
    check_eq("bounce_no_change", int'(state), m_state);
    press(6'b001000, 20);
    for (int i = 0; i < 8; i++) drive_cycle(1, 1, 1, 1, 0, 0);
    press(6'b001000, 20);

    // Speed and precision while counting down.
    press(6'b000010, 20);
    press(6'b010000, 20);
    press(6'b010000, 20);
    for (int i = 0; i < 20; i++) random_cycle_nozero();
    press(6'b100000, 20);
    for (int i = 0; i < 20; i++) random_cycle_nozero();

    // Simultaneous up and down: up wins.
    press(6'b000011, 20);

    // Low warning then expiry and the blink sequence.
    press(6'b000010, 20);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 1);
      drive_cycle(0, 0, 0, 0, 0, 1);
    end
    drive_cycle(1, 0, 1, 1, 1, 1);
    check_eq("expired_entry", int'(state), 4);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 1, 0, 0, 1, 1);
      drive_cycle(0, 0, 0, 0, 1, 1);
    end

    // Reset while expired with the LED lit.
    press(6'b000010, 20);
    drive_cycle(1, 1, 1, 1, 1, 1);
    drive_cycle(0, 1, 0, 0, 1, 1);
    check_eq("led_lit_before_reset", int'(led), 1);
    reset_cycles(1);

    for (int it = 0; it < 30; it++) begin
      logic [5:0] k;
      int r, hold;
      r = $urandom_range(0, 11);
      hold = 20 + $urandom_range(0, 4);
      case (r)
        0, 1:    k = 6'b000001;
        2, 3:    k = 6'b000010;
        4:       k = 6'b000100;
        5, 6:    k = 6'b001000;
        7:       k = 6'b010000;
        8:       k = 6'b100000;
        9:       k = 6'($urandom_range(1, 63));
        10: begin k = 6'($urandom_range(1, 63)); hold = 6; end
        default: k = 6'b000000;
      endcase
      press(k, hold);
      for (int i = 0; i < int'($urandom_range(20, 50)); i++) random_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic random_cycle_nozero();
    drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
  endtask

endmodule
